// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   dmem_req   : access request, high for the whole access
//   dmem_we    : 1 = store, 0 = load
//   dmem_addr  : byte address of the access
//   dmem_wdata : store data
//   dmem_rdata : load data, valid when dmem_ack = 1
//   dmem_ack   : access completes this cycle
// Modports: master = MEM stage, slave = memory.
interface mem_access_stage_if #(
  parameter int WORD_W = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic [WORD_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// LEGv8 MEM pipeline stage.
// Holds the EX/MEM register, resolves branches, runs data-memory accesses
// over a variable-latency req/ack bus (with an abort after TIMEOUT cycles),
// and drives the registered MEM/WB bundle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ex_valid, *_in      : EX stage results and control flags
//   stall               : hold EX and earlier stages this cycle
//   pc_src, branch_target : branch decision and target
//   dmem                : data-memory bus (master side)
//   wb_*                : MEM/WB register outputs
//   mem_error           : sticky access-timeout flag
module mem_access_stage #(
  parameter int WORD_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              uncondbranch_in,
  input  logic              branch_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        write_register_in,
  input  logic [WORD_W-1:0] alu_result_in,
  input  logic [WORD_W-1:0] read_data2_in,
  input  logic              zero_in,
  input  logic [WORD_W-1:0] branch_target_in,
  output logic              stall,
  output logic              pc_src,
  output logic [WORD_W-1:0] branch_target,
  mem_access_stage_if.master dmem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [4:0]        wb_write_register,
  output logic [WORD_W-1:0] wb_read_data,
  output logic [WORD_W-1:0] wb_alu_result,
  output logic              mem_error
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout;
  logic               load_done;
  logic               start;

  // EX/MEM register. Control flags are stored already qualified by
  // ex_valid, so a bubble entry can never request, branch or write.
  logic              valid_q, uncond_q, branch_q, mem_read_q, mem_write_q;
  logic              mem_to_reg_q, reg_write_q, zero_q;
  logic [4:0]        wreg_q;
  logic [WORD_W-1:0] alu_q, rd2_q, bt_q;

  // MEM/WB register.
  logic              wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q;
  logic [4:0]        wb_wreg_q;
  logic [WORD_W-1:0] wb_rdata_q, wb_alu_q;
  logic              mem_error_q;

  // A memory instruction is being accepted into EX/MEM on this edge.
  assign start = ex_valid & (mem_read_in | mem_write_in);

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    timeout   = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          // A load with both flags set is a store: no read data returned.
          load_done = mem_read_q & ~mem_write_q;
          state_d   = start ? BUSY : IDLE;
          cnt_d     = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: release the pipeline this cycle, bubble the access.
          timeout = 1'b1;
          state_d = start ? BUSY : IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_q | timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      uncond_q     <= 1'b0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      zero_q       <= 1'b0;
      wreg_q       <= '0;
      alu_q        <= '0;
      rd2_q        <= '0;
      bt_q         <= '0;
    end else if (!stall) begin
      valid_q      <= ex_valid;
      uncond_q     <= ex_valid & uncondbranch_in;
      branch_q     <= ex_valid & branch_in;
      mem_read_q   <= ex_valid & mem_read_in;
      mem_write_q  <= ex_valid & mem_write_in;
      mem_to_reg_q <= ex_valid & mem_to_reg_in;
      reg_write_q  <= ex_valid & reg_write_in;
      zero_q       <= zero_in;
      wreg_q       <= write_register_in;
      alu_q        <= alu_result_in;
      rd2_q        <= read_data2_in;
      bt_q         <= branch_target_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_wreg_q       <= '0;
      wb_rdata_q      <= '0;
      wb_alu_q        <= '0;
    end else if (stall || timeout) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
    end else begin
      wb_valid_q      <= valid_q;
      wb_reg_write_q  <= valid_q & reg_write_q;
      wb_mem_to_reg_q <= valid_q & mem_to_reg_q;
      wb_wreg_q       <= wreg_q;
      wb_alu_q        <= alu_q;
      if (load_done) wb_rdata_q <= dmem.dmem_rdata;
    end
  end

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = (state_q == BUSY) & mem_write_q;
  assign dmem.dmem_addr  = alu_q;
  assign dmem.dmem_wdata = rd2_q;

  assign pc_src        = valid_q & (uncond_q | (branch_q & zero_q));
  assign branch_target = bt_q;

  assign wb_valid          = wb_valid_q;
  assign wb_reg_write      = wb_reg_write_q;
  assign wb_mem_to_reg     = wb_mem_to_reg_q;
  assign wb_write_register = wb_wreg_q;
  assign wb_read_data      = wb_rdata_q;
  assign wb_alu_result     = wb_alu_q;
  assign mem_error         = mem_error_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage of the LEGv8 core, directly downstream of the execute stage.
- Registers the EX results (EX/MEM register) and resolves branches (pc_src).
- Runs data-memory loads and stores over a variable-latency req/ack interface. Stalls upstream while an access is outstanding.
- Drives a registered MEM/WB bundle to write-back. Memory width is `WORD (64 bits).

Parameters:
WORD_W, `WORD (64), data/address width
TIMEOUT, 16, max BUSY cycles without dmem_ack before abort (>=2)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset, fixed
ex_valid  input  1  EX output holds a real instruction (0 = bubble)
uncondbranch_in, branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  input  1 each  EX control flags
write_register_in  input  5  destination register
alu_result_in  input  WORD_W  ALU result / memory address
read_data2_in  input  WORD_W  store data
zero_in  input  1  ALU zero flag
branch_target_in  input  WORD_W  PC + (imm<<2)
stall  output  1  hold EX and earlier stages this cycle
pc_src  output  1  branch taken, select branch_target
branch_target  output  WORD_W  registered branch_target_in
dmem_req, dmem_we  output  1 each  access request / write enable
dmem_addr, dmem_wdata  output  WORD_W  address / store data
dmem_rdata  input  WORD_W  load data, valid when dmem_ack=1
dmem_ack  input  1  access complete this cycle
wb_valid, wb_reg_write, wb_mem_to_reg  output  1 each  MEM/WB control
wb_write_register  output  5  MEM/WB destination
wb_read_data, wb_alu_result  output  WORD_W  MEM/WB data
mem_error  output  1  sticky timeout flag

Behaviour:
- Reset:
  - All registers and outputs go to 0, FSM goes to IDLE, timeout counter goes to 0, mem_error goes to 0.
  - dmem_req is low from the first cycle after the reset edge.
  - A dmem_ack arriving after reset in IDLE is ignored.
- EX/MEM register:
  - Loads all *_in signals (valid = ex_valid) on posedge when stall=0.
  - Holds its contents when stall=1.
  - Stored flags are qualified by valid. An invalid entry never requests, branches or writes.
- FSM states IDLE and BUSY:
  - IDLE -> BUSY on the same edge that loads a valid entry with mem_read or mem_write set.
  - BUSY -> IDLE on the edge where dmem_ack=1, or on timeout.
  - If mem_read and mem_write are both set, the access is treated as a store.
- Memory interface:
  - dmem_req = (state==BUSY). This is a combinational decode of the state register.
  - dmem_we = BUSY & mem_write.
  - dmem_addr = stored alu_result; dmem_wdata = stored read_data2.
  - Held stable throughout BUSY.
- Stall:
  - stall = BUSY & ~dmem_ack (combinational).
  - Zero-wait memory (ack in the first BUSY cycle) means no stall. Each BUSY cycle without ack adds one stall cycle.
- Timeout:
  - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On the cycle where the count reaches TIMEOUT-1 with no ack, stall=0 that cycle. At the following edge: state goes to IDLE, mem_error is set to 1 (held until reset), and the MEM/WB bubble rule below applies (load data discarded, store dropped).
- Branch resolution (combinational from the EX/MEM register):
  - pc_src = valid & (uncondbranch | (branch & zero)).
  - branch_target = stored branch_target.
- MEM/WB register, updated every posedge:
  - Stall=1 cycle: load a bubble (wb_valid=0, wb_reg_write=0).
  - Timeout edge: load a bubble.
  - Otherwise: wb_valid = valid, wb_reg_write = valid & reg_write, wb_mem_to_reg = mem_to_reg, wb_write_register, wb_alu_result = stored alu_result, wb_read_data = dmem_rdata if the load completed this edge, else hold the previous value.
- Latency: a non-memory instruction reaches MEM/WB 2 edges after leaving EX; a load takes 2 edges plus its wait cycles.

Test Plan:
- Reset: assert reset 2 cycles mid-BUSY -> next cycle dmem_req=0, stall=0, mem_error=0, all wb_* = 0; a subsequent stray dmem_ack=1 leaves state IDLE.
- ADD (ex_valid=1, reg_write=1, alu_result=0x10, write_register=5) -> dmem_req never 1, stall=0, one edge after the EX/MEM load wb_alu_result=0x10, wb_write_register=5, wb_reg_write=1.
- LDUR (mem_read=1, mem_to_reg=1, alu_result=0x80), ack in the 3rd BUSY cycle with rdata=0xDEADBEEF -> dmem_addr=0x80, stall=1 for exactly 2 cycles, wb_read_data=0xDEADBEEF with wb_mem_to_reg=1. The next EX instruction is loaded only on the ack edge.
- STUR (mem_write=1, alu_result=0x40, read_data2=0x55), ack same cycle -> dmem_we=1, dmem_wdata=0x55, stall never 1, wb_reg_write=0.
- Branches:
  - CBZ (branch=1, zero=1, branch_target=0x100) -> pc_src=1, branch_target=0x100.
  - Same with zero=0 -> pc_src=0.
  - B (uncondbranch=1) -> pc_src=1.
  - ex_valid=0 with branch=1, zero=1 -> pc_src=0.
- Timeout (TIMEOUT=4), LDUR with no ack -> stall=1 for 3 cycles, stall=0 in the 4th, mem_error=1 after that edge and stays 1 across later instructions, wb_valid=0 for the aborted load, next instruction proceeds normally.
